// File: rtl/vppm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vppm_pkg
//  Description : Shared constants for the VPPM demodulator slice: state
//                encoding of the decision FSM and default geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package vppm_pkg;

    // Default symbol geometry
    localparam int c_SPS_DEFAULT   = 32;
    localparam int c_NBCNT_DEFAULT = 8;

    // Decision FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RX   = 1'b1;

endpackage : vppm_pkg
`default_nettype wire

// File: rtl/vppm_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : vppm_slicer
//  Description : Hysteresis slicer for the filtered sample stream. Produces
//                the light level of the current valid sample and a rise flag
//                (0->1 between consecutive valid samples).
//  Revision    : 1.0  initial release
// ============================================================================
module vppm_slicer #(
    parameter int NBITS1 = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [NBITS1-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic signed [NBITS1-1:0] thresh_hi,
    input  logic signed [NBITS1-1:0] thresh_lo,
    output logic                     level,
    output logic                     rise
);

    logic r_level;
    logic w_level_next;

    // Level the current sample resolves to; the rising threshold wins when
    // both thresholds are satisfied, otherwise the previous level is held.
    always_comb begin
        w_level_next = r_level;
        if (sample_in >= thresh_hi) begin
            w_level_next = 1'b1;
        end else if (sample_in <= thresh_lo) begin
            w_level_next = 1'b0;
        end
    end

    // Remember the level of the last valid sample for rise detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
        end else if (sample_valid) begin
            r_level <= w_level_next;
        end
    end

    // Current-sample level is exposed combinationally so the demodulator can
    // count the very sample that caused a rise.
    assign level = w_level_next;
    assign rise  = sample_valid & w_level_next & ~r_level;

endmodule : vppm_slicer
`default_nettype wire

// File: rtl/vppm_demod.sv
`default_nettype none
// ============================================================================
//  Module      : vppm_demod
//  Description : VPPM demodulator. Slices filtered samples with hysteresis,
//                acquires symbol timing from a rise after a dark period and
//                decides one bit per symbol by comparing high-sample counts
//                of the two symbol halves.
//  Config      : DUTY_OUT_EN - adds duty_out, the high-sample total of each
//                decided symbol (dimming estimate).
//  Revision    : 1.0  initial release
// ============================================================================
module vppm_demod
    import vppm_pkg::*;
#(
    parameter int NBITS1 = 16,
    parameter int SPS    = c_SPS_DEFAULT,
    parameter int NBCNT  = c_NBCNT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [NBITS1-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic signed [NBITS1-1:0] thresh_hi,
    input  logic signed [NBITS1-1:0] thresh_lo,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic                     bit_err,
    output logic                     locked,
    output logic                     frame_end
`ifdef DUTY_OUT_EN
    ,
    output logic [NBCNT-1:0]         duty_out
`endif
);

    localparam logic [NBCNT-1:0] c_SPS  = NBCNT'(SPS);
    localparam logic [NBCNT-1:0] c_HALF = NBCNT'(SPS / 2);
    localparam logic [NBCNT-1:0] c_LAST = NBCNT'(SPS - 1);
    localparam logic [NBCNT-1:0] c_ONE  = NBCNT'(1);

    logic [0:0]       r_state;
    logic [NBCNT-1:0] r_low_run;
    logic [NBCNT-1:0] r_sym_idx;
    logic [NBCNT-1:0] r_cnt_a;
    logic [NBCNT-1:0] r_cnt_b;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_bit_err;
    logic             r_frame_end;

    logic             w_level;
    logic             w_rise;
    logic             w_in_a;
    logic             w_last;
    logic             w_dark;
    logic [NBCNT-1:0] w_cnt_a_next;
    logic [NBCNT-1:0] w_cnt_b_next;

    vppm_slicer #(
        .NBITS1       (NBITS1)
    ) u_slicer (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .level        (w_level),
        .rise         (w_rise)
    );

    // Half-counts including the current sample, so the last sample of a
    // symbol takes part in its own decision.
    always_comb begin
        w_in_a       = (r_sym_idx < c_HALF);
        w_last       = (r_sym_idx == c_LAST);
        w_cnt_a_next = r_cnt_a;
        w_cnt_b_next = r_cnt_b;
        if (w_level) begin
            if (w_in_a) begin
                w_cnt_a_next = r_cnt_a + c_ONE;
            end else begin
                w_cnt_b_next = r_cnt_b + c_ONE;
            end
        end
        w_dark = (w_cnt_a_next == '0) && (w_cnt_b_next == '0);
    end

    // Acquisition / decision FSM with symbol counters and output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_low_run   <= '0;
            r_sym_idx   <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_err   <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            r_frame_end <= 1'b0;
            if (sample_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise && (r_low_run == c_SPS)) begin
                            // Rising sample is index 0 of the first symbol;
                            // counters are already clear in idle.
                            r_state   <= ST_RX;
                            r_cnt_a   <= w_cnt_a_next;
                            r_cnt_b   <= w_cnt_b_next;
                            r_sym_idx <= c_ONE;
                            r_low_run <= '0;
                        end else if (w_level) begin
                            r_low_run <= '0;
                        end else if (r_low_run != c_SPS) begin
                            r_low_run <= r_low_run + c_ONE;
                        end
                    end
                    ST_RX: begin
                        if (w_last) begin
                            r_sym_idx <= '0;
                            r_cnt_a   <= '0;
                            r_cnt_b   <= '0;
                            if (w_dark) begin
                                // A fully dark symbol ends the frame and
                                // already counts as a full low run.
                                r_state     <= ST_IDLE;
                                r_frame_end <= 1'b1;
                                r_low_run   <= c_SPS;
                            end else begin
                                r_bit_valid <= 1'b1;
                                r_bit_out   <= (w_cnt_b_next > w_cnt_a_next);
                                r_bit_err   <= (w_cnt_b_next == w_cnt_a_next);
                            end
                        end else begin
                            r_sym_idx <= r_sym_idx + c_ONE;
                            r_cnt_a   <= w_cnt_a_next;
                            r_cnt_b   <= w_cnt_b_next;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_OUT_EN
    logic [NBCNT-1:0] r_duty;

    // Dimming estimate: total high samples of each decided symbol
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else if (sample_valid && (r_state == ST_RX) && w_last && !w_dark) begin
            r_duty <= w_cnt_a_next + w_cnt_b_next;
        end
    end

    assign duty_out = r_duty;
`endif

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_err   = r_bit_err;
    assign frame_end = r_frame_end;
    assign locked    = (r_state == ST_RX);

endmodule : vppm_demod
`default_nettype wire

// File: tb/tb_vppm_demod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vppm_demod
//  Description : Directed self-checking bench for vppm_demod (SPS=32,
//                thresh_hi=500, thresh_lo=200). Honours DUTY_OUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vppm_demod;

    logic               clk;
    logic               rst;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic signed [15:0] thresh_hi;
    logic signed [15:0] thresh_lo;
    logic               bit_out;
    logic               bit_valid;
    logic               bit_err;
    logic               locked;
    logic               frame_end;
`ifdef DUTY_OUT_EN
    logic [7:0]         duty_out;
`endif

    int errors;
    int checks;
    int n_valid;
    int n_fend;

    vppm_demod #(
        .NBITS1       (16),
        .SPS          (32),
        .NBCNT        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_err      (bit_err),
        .locked       (locked),
        .frame_end    (frame_end)
`ifdef DUTY_OUT_EN
        ,
        .duty_out     (duty_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters, so stray pulses anywhere are noticed
    always @(posedge clk) begin
        if (bit_valid === 1'b1) n_valid++;
        if (frame_end === 1'b1) n_fend++;
    end

    task automatic send_run(input logic signed [15:0] v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            sample_in    = v;
            sample_valid = 1'b1;
            @(posedge clk); #1;
            if (gap) begin
                sample_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        idle(3);
        checks++;
        if ({bit_out, bit_valid, bit_err, locked, frame_end} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000", {bit_out, bit_valid, bit_err, locked, frame_end});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_duty got %0d exp 0", duty_out);
        end
`endif
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_dark_start();
        int nv;
        nv = n_valid;
        send_run(16'sd0, 40, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL dark_prelock locked got %b exp 0", locked);
        end
        send_run(16'sd1000, 1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL dark_lock locked got %b exp 1", locked);
        end
        send_run(16'sd1000, 11, 1'b0);
        send_run(16'sd0, 20, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b100) begin
            errors++;
            $display("FAIL dark_bit0 valid/out/err got %b exp 100", {bit_valid, bit_out, bit_err});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd12) begin
            errors++;
            $display("FAIL dark_duty got %0d exp 12", duty_out);
        end
`endif
        idle(1);
        checks++;
        if (n_valid - nv !== 1) begin
            errors++;
            $display("FAIL dark_count bit_valid pulses got %0d exp 1", n_valid - nv);
        end
    endtask

    task automatic test_bit_one();
        send_run(16'sd0, 16, 1'b1);
        send_run(16'sd1000, 12, 1'b0);
        send_run(16'sd0, 4, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b110) begin
            errors++;
            $display("FAIL bit1 valid/out/err got %b exp 110", {bit_valid, bit_out, bit_err});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd12) begin
            errors++;
            $display("FAIL bit1_duty got %0d exp 12", duty_out);
        end
`endif
        idle(1);
        checks++;
        if ({bit_valid, locked} !== 2'b01) begin
            errors++;
            $display("FAIL bit1_strobe_drop valid/locked got %b exp 01", {bit_valid, locked});
        end
    endtask

    task automatic test_hysteresis();
        send_run(16'sd0, 16, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_run(16'sd600, 1, 1'b0);
            send_run(16'sd300, 1, 1'b0);
        end
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b110) begin
            errors++;
            $display("FAIL hyst valid/out/err got %b exp 110", {bit_valid, bit_out, bit_err});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd16) begin
            errors++;
            $display("FAIL hyst_duty got %0d exp 16", duty_out);
        end
`endif
        idle(1);
    endtask

    task automatic test_tie();
        send_run(16'sd1000, 8, 1'b0);
        send_run(16'sd0, 8, 1'b0);
        send_run(16'sd1000, 8, 1'b0);
        send_run(16'sd0, 8, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b101) begin
            errors++;
            $display("FAIL tie valid/out/err got %b exp 101", {bit_valid, bit_out, bit_err});
        end
        idle(2);
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd16) begin
            errors++;
            $display("FAIL tie_duty_hold got %0d exp 16", duty_out);
        end
`endif
    endtask

    task automatic test_boundaries();
        // Highs at indices 15 and 16 straddle the half split: a tie
        send_run(16'sd0, 15, 1'b0);
        send_run(16'sd1000, 2, 1'b0);
        send_run(16'sd0, 15, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b101) begin
            errors++;
            $display("FAIL half_split valid/out/err got %b exp 101", {bit_valid, bit_out, bit_err});
        end
        idle(1);
        // Index 0 high, indices 30 and 31 high: the last sample breaks the tie
        send_run(16'sd1000, 1, 1'b0);
        send_run(16'sd0, 29, 1'b0);
        send_run(16'sd1000, 2, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b110) begin
            errors++;
            $display("FAIL last_sample valid/out/err got %b exp 110", {bit_valid, bit_out, bit_err});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd3) begin
            errors++;
            $display("FAIL last_sample_duty got %0d exp 3", duty_out);
        end
`endif
        idle(1);
    endtask

    task automatic test_dark_symbol();
        int nv;
        int nf;
        nv = n_valid;
        nf = n_fend;
        send_run(16'sd0, 32, 1'b0);
        checks++;
        if ({bit_valid, frame_end, locked} !== 3'b010) begin
            errors++;
            $display("FAIL dark_sym valid/fend/locked got %b exp 010", {bit_valid, frame_end, locked});
        end
        idle(1);
        checks++;
        if ((n_valid - nv !== 0) || (n_fend - nf !== 1) || (frame_end !== 1'b0)) begin
            errors++;
            $display("FAIL dark_sym_pulses valid=%0d fend=%0d fend_now=%b exp 0 1 0",
                     n_valid - nv, n_fend - nf, frame_end);
        end
        send_run(16'sd1000, 1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_immediate locked got %b exp 1", locked);
        end
        send_run(16'sd1000, 3, 1'b0);
        send_run(16'sd0, 28, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b100) begin
            errors++;
            $display("FAIL relock_bit valid/out/err got %b exp 100", {bit_valid, bit_out, bit_err});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd4) begin
            errors++;
            $display("FAIL relock_duty got %0d exp 4", duty_out);
        end
`endif
        idle(1);
    endtask

    task automatic test_reset_mid();
        int nv;
        send_run(16'sd1000, 10, 1'b0);
        nv = n_valid;
        rst = 1'b1;
        sample_in = 16'sd1000;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bit_out, bit_valid, bit_err, locked, frame_end} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid outputs got %b exp 00000", {bit_out, bit_valid, bit_err, locked, frame_end});
        end
        send_run(16'sd0, 10, 1'b0);
        send_run(16'sd1000, 1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_short_dark locked got %b exp 0", locked);
        end
        send_run(16'sd0, 32, 1'b0);
        send_run(16'sd1000, 1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL rst_relock locked got %b exp 1", locked);
        end
        send_run(16'sd1000, 15, 1'b0);
        send_run(16'sd0, 16, 1'b0);
        checks++;
        if ({bit_valid, bit_out, bit_err} !== 3'b100) begin
            errors++;
            $display("FAIL rst_relock_bit valid/out/err got %b exp 100", {bit_valid, bit_out, bit_err});
        end
`ifdef DUTY_OUT_EN
        checks++;
        if (duty_out !== 8'd16) begin
            errors++;
            $display("FAIL rst_relock_duty got %0d exp 16", duty_out);
        end
`endif
        idle(1);
        checks++;
        if (n_valid - nv !== 1) begin
            errors++;
            $display("FAIL rst_pulse_count got %0d exp 1", n_valid - nv);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        n_valid      = 0;
        n_fend       = 0;
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        thresh_hi    = 16'sd500;
        thresh_lo    = 16'sd200;
        test_reset();
        test_dark_start();
        test_bit_one();
        test_hysteresis();
        test_tie();
        test_boundaries();
        test_dark_symbol();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vppm_demod
`default_nettype wire
